microphone_spi_reader: RTL
==========================

MICROPHONE_SPI_READER -- requirements
Module: microphone_spi_reader

Interface
REQ-001 SHALL have parameter ClockDivider, default 25, the SCLK half-period in inputClock cycles; legal range 2..255.
REQ-002 SHALL have parameter FrameBits, default 16, the SCLK rising edges per conversion frame; legal range 10..32.
REQ-003 SHALL have parameter LeadingBits, default 3, the frame bits before the data MSB; FrameBits >= LeadingBits+8 is required.
REQ-004 SHALL have port inputClock, input, 1, the single system clock (50 MHz board clock).
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sampleStrobe, input, 1, a one-cycle request to start one conversion frame.
REQ-007 SHALL have port spi_miso, input, 1, ADC serial data, MSB first.
REQ-008 SHALL have port spi_sclk, output, 1, SPI clock; idles high (CPOL=1).
REQ-009 SHALL have port spi_cs_n, output, 1, active-low ADC chip select.
REQ-010 SHALL have port outputSample, output, 8, the last completed sample; drop-in for microphoneInputSample.
REQ-011 SHALL have port sampleValid, output, 1, a one-cycle pulse when outputSample updates.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have port overrunCount, output, 8, a saturating count of dropped strobes.

Function
REQ-014 SHALL implement the states IDLE, SETUP, SHIFT and HOLD.
REQ-015 IDLE: sampleStrobe high at edge k -> SETUP; spi_cs_n=0 and busy=1 from cycle k+1.
REQ-016 SETUP: SHALL last ClockDivider cycles with spi_sclk=1, then go to SHIFT.
REQ-017 SHIFT: each bit SHALL drive spi_sclk=0 for ClockDivider cycles, then 1 for ClockDivider cycles, repeated FrameBits times.
REQ-018 SHALL capture spi_miso into an N-bit MSB-first shift register on the inputClock edge where spi_sclk goes 0->1.
REQ-019 After the FrameBits-th high phase, the block SHALL go to HOLD with spi_cs_n=1 and spi_sclk=1.
REQ-020 HOLD: on the first cycle, outputSample SHALL be set to shift bits [FrameBits-1-LeadingBits -: 8], and sampleValid SHALL be 1 for that cycle only.
REQ-021 HOLD SHALL last ClockDivider cycles, then go to IDLE.
REQ-022 Latency: with defaults, strobe at edge k -> sampleValid at cycle k+826; busy high on cycles k+1..k+850.
REQ-023 A sampleStrobe while busy=1 SHALL be ignored and SHALL increment overrunCount, saturating at 255.
REQ-024 A strobe on the first IDLE cycle after HOLD SHALL be accepted; it is not an overrun.
REQ-025 outputSample SHALL hold its value between sampleValid pulses.
REQ-026 Neither spi_sclk nor spi_cs_n SHALL glitch; both SHALL be driven directly from flops.
REQ-027 The frame counter SHALL be wide enough for FrameBits=32 and the half-period counter for 255, with no wrap inside a frame.

Reset
REQ-028 reset_n low SHALL immediately (asynchronously) force the IDLE state, spi_cs_n=1, spi_sclk=1, outputSample=0, sampleValid=0, busy=0, overrunCount=0 and clear the shift register.
REQ-029 A reset mid-frame SHALL discard the partial frame; no sampleValid pulse for it.
REQ-030 After reset release, the first strobe SHALL start a full frame from SETUP.

Structure
REQ-031 Package mic_spi_pkg SHALL hold the state enum (IDLE=0, SETUP=1, SHIFT=2, HOLD=3) and the default constants (25, 16, 3).
REQ-032 One sub-module, SpiBitTimer, SHALL hold the half-period counter and emit halfPeriodDone; everything else stays inline.

Verification
REQ-033 Reset, then one strobe; the ADC model returns 000_10110101_00000 -> spi_cs_n low for 825 cycles, 16 SCLK rising edges, outputSample=0xB5 with sampleValid at k+826.
REQ-034 ADC model returns all ones (0xFFFF) -> outputSample=0xFF; the leading and trailing bits are ignored.
REQ-035 Three strobes issued 100 cycles apart during one frame -> overrunCount=3; a single sampleValid pulse.
REQ-036 Strobe on the exact first IDLE cycle after HOLD -> a new frame starts the next cycle; overrunCount unchanged.
REQ-037 reset_n pulsed low at cycle k+400 of a frame -> spi_cs_n=1 and spi_sclk=1 immediately; outputSample=0; no sampleValid.
REQ-038 Strobe every 1562 cycles (32 kHz) for 10 frames with a ramp ADC model -> 10 sampleValid pulses carrying the correct ramp values; overrunCount=0.

Source files
------------

// File: rtl/mic_spi_pkg.sv
// Shared types and default constants for the microphone SPI ADC reader.
package mic_spi_pkg;

  // Frame sequencer states; encodings are fixed so they read the same in any waveform.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Default timing: 25-cycle SCLK half-period (1 MHz SCLK from 50 MHz),
  // 16-bit frame, 3 leading bits before the 8-bit sample MSB.
  localparam int DefaultClockDivider = 25;
  localparam int DefaultFrameBits    = 16;
  localparam int DefaultLeadingBits  = 3;

  // Frame counter holds 0..FrameBits-1 for FrameBits up to 32.
  localparam int BitCntW = 6;

  // Half-period counter holds 0..ClockDivider-1 for ClockDivider up to 255.
  localparam int HalfCntW = 8;

  // Increment that sticks at 255 instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/microphone_spi_reader_bit_timer.sv
// SpiBitTimer: counts inputClock cycles inside one SCLK half-period and flags
// the last cycle of each half-period. Restarts from zero whenever it is idle.
module SpiBitTimer
  import mic_spi_pkg::*;
#(
  parameter int HalfPeriod = DefaultClockDivider
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_half_period_done
);

  logic [HalfCntW-1:0] r_count;

  // The final cycle of a half-period; the count rolls to zero on the next edge,
  // so every half-period is exactly HalfPeriod cycles long.
  assign o_half_period_done = i_run && (r_count == HalfCntW'(HalfPeriod - 1));

  // Half-period cycle counter, held at zero while the sequencer is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values,
    // independent of the order in which always blocks are evaluated.
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (!i_run || o_half_period_done) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + HalfCntW'(1);
    end
  end

endmodule

// File: rtl/microphone_spi_reader.sv
// microphone_spi_reader: on each sampleStrobe, runs one CPOL=1 SPI frame
// against the microphone ADC and publishes 8 bits of the returned word.
// Frame shape: SETUP (CS low, SCLK high) -> FrameBits low/high SCLK periods
// with MISO captured on each rising edge -> HOLD (CS high, sample published).
module microphone_spi_reader
  import mic_spi_pkg::*;
#(
  parameter int ClockDivider = DefaultClockDivider,
  parameter int FrameBits    = DefaultFrameBits,
  parameter int LeadingBits  = DefaultLeadingBits
) (
  input  logic       inputClock,
  input  logic       reset_n,
  input  logic       sampleStrobe,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic [7:0] outputSample,
  output logic       sampleValid,
  output logic       busy,
  output logic [7:0] overrunCount
);

  // Position of the sample MSB inside the captured frame.
  localparam int SampleMsb = FrameBits - 1 - LeadingBits;

  state_t               r_state;
  logic                 r_sclk;
  logic                 r_cs_n;
  logic                 r_busy;
  logic                 r_valid;
  logic [7:0]           r_sample;
  logic [7:0]           r_overrun;
  logic [FrameBits-1:0] r_shift;
  logic [BitCntW-1:0]   r_bit_cnt;

  logic                 w_half_period_done;
  logic                 w_timer_run;

  // The half-period timer runs for every state except IDLE, so each of
  // SETUP, every SCLK phase and HOLD is timed by the same counter.
  assign w_timer_run = (r_state != IDLE);

  SpiBitTimer #(
    .HalfPeriod (ClockDivider)
  ) u_bit_timer (
    .i_clk              (inputClock),
    .i_rst_n            (reset_n),
    .i_run              (w_timer_run),
    .o_half_period_done (w_half_period_done)
  );

  // All outputs come straight from flops so SCLK and CS never glitch.
  assign spi_sclk     = r_sclk;
  assign spi_cs_n     = r_cs_n;
  assign busy         = r_busy;
  assign sampleValid  = r_valid;
  assign outputSample = r_sample;
  assign overrunCount = r_overrun;

  // Frame sequencer with registered SPI pins, sample output and overrun count.
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_sclk    <= 1'b1;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_sample  <= 8'h00;
      r_overrun <= 8'h00;
      // NOTE: the shift register is an ordinary flop bank, so clearing it on
      // reset is cheap and keeps a partial frame from leaking into later reads.
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      // sampleValid is a single-cycle pulse unless HOLD is being entered.
      r_valid <= 1'b0;

      // A strobe that arrives mid-frame is dropped and counted.
      if (sampleStrobe && r_busy) begin
        r_overrun <= sat_inc8(r_overrun);
      end

      case (r_state)
        IDLE: begin
          if (sampleStrobe) begin
            r_state   <= SETUP;
            r_cs_n    <= 1'b0;
            r_sclk    <= 1'b1;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end

        SETUP: begin
          // CS has been low with SCLK high for one half-period; start bit 0.
          if (w_half_period_done) begin
            r_state <= SHIFT;
            r_sclk  <= 1'b0;
          end
        end

        SHIFT: begin
          if (w_half_period_done) begin
            if (!r_sclk) begin
              // Low phase over: raise SCLK and capture MISO on that same edge.
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[FrameBits-2:0], spi_miso};
            end else if (r_bit_cnt == BitCntW'(FrameBits - 1)) begin
              // Last high phase over: release CS, keep SCLK idle high, publish.
              r_state  <= HOLD;
              r_cs_n   <= 1'b1;
              r_sample <= r_shift[SampleMsb -: 8];
              r_valid  <= 1'b1;
            end else begin
              r_sclk    <= 1'b0;
              r_bit_cnt <= r_bit_cnt + BitCntW'(1);
            end
          end
        end

        HOLD: begin
          // Gives the ADC its CS-high recovery time before the next frame.
          if (w_half_period_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
